// File: rtl/pwr_seq_ctrl_if.sv
// Bundle of signals between the rail sequencer, the rail/power-good
// hardware and its companion `delay` counter.
//   iEn        : power request level (high = up, low = down)
//   iPwrGood   : per-rail power-good, synchronous to the sequencer clock
//   iDlyDone   : done flag from the `delay` counter
//   oDlyStart  : `delay` start, high only while a spacing interval runs
//   oDlyClr    : `delay` counter clear, high while idle or faulted
//   oRailEn    : rail enables
//   oReady     : all rails up and good
//   oFault     : sticky fault flag
//   oFaultRail : index of the rail that caused the last fault
// slave  : the sequencer's view
// master : the environment's view (rails, supervisor, delay counter)
interface pwr_seq_ctrl_if #(
  parameter int RAILS = 4,
  parameter int IDX_W = ($clog2(RAILS) < 1) ? 1 : $clog2(RAILS)
);
  logic             iEn;
  logic [RAILS-1:0] iPwrGood;
  logic             iDlyDone;
  logic             oDlyStart;
  logic             oDlyClr;
  logic [RAILS-1:0] oRailEn;
  logic             oReady;
  logic             oFault;
  logic [IDX_W-1:0] oFaultRail;

  modport slave (
    input  iEn, iPwrGood, iDlyDone,
    output oDlyStart, oDlyClr, oRailEn, oReady, oFault, oFaultRail
  );

  modport master (
    output iEn, iPwrGood, iDlyDone,
    input  oDlyStart, oDlyClr, oRailEn, oReady, oFault, oFaultRail
  );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// Rail power sequencer. Enables RAILS rails one at a time in ascending
// order and disables them in descending order, using an external `delay`
// counter to space the steps. Power-good is supervised on the way up and
// while all rails are on; a bad rail drops every rail at once and latches
// a sticky fault with the failing rail index.
// Ports:
//   iClk   : clock, all logic on the rising edge
//   iRst   : asynchronous active-high reset; rails drop immediately
//   seqBus : pwr_seq_ctrl_if slave modport (request, power-good, delay
//            handshake, rail enables and status)
// All outputs are registered and decoded from the next state.
module pwr_seq_ctrl #(
  parameter int RAILS = 4,
  parameter int IDX_W = ($clog2(RAILS) < 1) ? 1 : $clog2(RAILS)
) (
  input logic           iClk,
  input logic           iRst,
  pwr_seq_ctrl_if.slave seqBus
);

  typedef enum logic [2:0] {
    IDLE,
    UP_EN,
    UP_WAIT,
    ON,
    DN_DIS,
    DN_WAIT,
    FAULT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAILS - 1);

  state_t           state, stateNxt;
  logic [IDX_W-1:0] k, kNxt;
  logic [RAILS-1:0] railEn, railEnNxt;
  logic             ready, readyNxt;
  logic             fault, faultNxt;
  logic [IDX_W-1:0] faultRail, faultRailNxt;
  logic             dlyStart, dlyStartNxt;
  logic             dlyClr, dlyClrNxt;

  logic             en;
  logic [RAILS-1:0] pwrGood;
  logic             dlyDone;

  logic             anyBad;
  logic [IDX_W-1:0] lowBad;
  logic             anyBadBelow;
  logic [IDX_W-1:0] lowBadBelow;

  assign en      = seqBus.iEn;
  assign pwrGood = seqBus.iPwrGood;
  assign dlyDone = seqBus.iDlyDone;

  assign seqBus.oDlyStart  = dlyStart;
  assign seqBus.oDlyClr    = dlyClr;
  assign seqBus.oRailEn    = railEn;
  assign seqBus.oReady     = ready;
  assign seqBus.oFault     = fault;
  assign seqBus.oFaultRail = faultRail;

  // Lowest failing rail overall, and lowest failing rail among those
  // already enabled below the rail currently being brought up. Scanning
  // downward leaves the lowest index as the final assignment.
  always_comb begin
    anyBad      = 1'b0;
    lowBad      = '0;
    anyBadBelow = 1'b0;
    lowBadBelow = '0;
    for (int i = RAILS - 1; i >= 0; i--) begin
      if (!pwrGood[i]) begin
        anyBad = 1'b1;
        lowBad = IDX_W'(i);
        if (IDX_W'(i) < k) begin
          anyBadBelow = 1'b1;
          lowBadBelow = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    stateNxt     = state;
    kNxt         = k;
    railEnNxt    = railEn;
    faultRailNxt = faultRail;

    unique case (state)
      IDLE: begin
        if (en) begin
          stateNxt = UP_EN;
          kNxt     = '0;
        end
      end

      UP_EN: stateNxt = UP_WAIT;

      UP_WAIT: begin
        if (anyBadBelow) begin
          stateNxt     = FAULT;
          faultRailNxt = lowBadBelow;
        end else if (!en) begin
          // Power down starts from the rail just enabled.
          stateNxt = DN_DIS;
        end else if (dlyDone) begin
          if (!pwrGood[k]) begin
            stateNxt     = FAULT;
            faultRailNxt = k;
          end else if (k == LAST_IDX) begin
            stateNxt = ON;
          end else begin
            stateNxt = UP_EN;
            kNxt     = k + IDX_W'(1);
          end
        end
      end

      ON: begin
        // A bad rail wins over a simultaneous power-down request.
        if (anyBad) begin
          stateNxt     = FAULT;
          faultRailNxt = lowBad;
        end else if (!en) begin
          stateNxt = DN_DIS;
          kNxt     = LAST_IDX;
        end
      end

      DN_DIS: stateNxt = DN_WAIT;

      DN_WAIT: begin
        if (dlyDone) begin
          if (k == '0) begin
            stateNxt = IDLE;
          end else begin
            stateNxt = DN_DIS;
            kNxt     = k - IDX_W'(1);
          end
        end
      end

      FAULT: begin
        if (!en) begin
          stateNxt = IDLE;
        end
      end

      default: stateNxt = IDLE;
    endcase

    // Registered outputs decoded from the next state. The single cycle of
    // dlyStart low in UP_EN/DN_DIS clears the delay counter so a stale
    // done is never seen in the following wait state.
    unique case (stateNxt)
      UP_EN:       railEnNxt[kNxt] = 1'b1;
      DN_DIS:      railEnNxt[kNxt] = 1'b0;
      FAULT, IDLE: railEnNxt       = '0;
      default:     railEnNxt       = railEn;
    endcase

    readyNxt    = (stateNxt == ON);
    faultNxt    = (stateNxt == FAULT);
    dlyStartNxt = (stateNxt == UP_WAIT) || (stateNxt == DN_WAIT);
    dlyClrNxt   = (stateNxt == IDLE) || (stateNxt == FAULT);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      k         <= '0;
      railEn    <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      faultRail <= '0;
      dlyStart  <= 1'b0;
      dlyClr    <= 1'b1;
    end else begin
      state     <= stateNxt;
      k         <= kNxt;
      railEn    <= railEnNxt;
      ready     <= readyNxt;
      fault     <= faultNxt;
      faultRail <= faultRailNxt;
      dlyStart  <= dlyStartNxt;
      dlyClr    <= dlyClrNxt;
    end
  end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Bench for pwr_seq_ctrl: directed sequences followed by randomized
// request/power-good activity, with a companion delay counter (COUNT=C).
// The reference model tracks rails-on count and a spacing timer and
// pushes expected output vectors; a monitor compares every output change.
module tb_pwr_seq_ctrl;
  localparam int RAILS = 4;
  localparam int IDX_W = 2;
  localparam int C     = 3;

  localparam int M_OFF  = 0;
  localparam int M_UP   = 1;
  localparam int M_ON   = 2;
  localparam int M_DOWN = 3;
  localparam int M_FLT  = 4;

  typedef struct {
    int         cyc;
    logic [9:0] v;
  } exp_t;

  logic iClk;
  logic iRst;

  pwr_seq_ctrl_if #(.RAILS(RAILS), .IDX_W(IDX_W)) bus ();

  pwr_seq_ctrl #(.RAILS(RAILS), .IDX_W(IDX_W)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .seqBus(bus)
  );

  int   dlyCnt;
  int   edgeCnt = 0;
  int   total   = 0;
  int   bad     = 0;
  exp_t expQ[$];

  // Reference model state
  int         mMode;
  int         mN;      // number of rails enabled
  int         mT;      // edges since the last rail change
  logic [1:0] mFR;
  logic [9:0] mPrevV;

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) edgeCnt <= edgeCnt + 1;

  // Companion delay counter: done once start has been high for C edges.
  always @(posedge iClk or posedge iRst) begin
    if (iRst) dlyCnt <= 0;
    else if (!bus.oDlyStart || bus.oDlyClr) dlyCnt <= 0;
    else if (dlyCnt < C) dlyCnt <= dlyCnt + 1;
  end
  assign bus.iDlyDone = (dlyCnt == C);

  function automatic int lowestBad(input logic [3:0] pg, input int lim);
    for (int j = 0; j < lim; j++) if (!pg[j]) return j;
    return -1;
  endfunction

  function automatic logic [9:0] modelVec();
    logic [3:0] r;
    logic       st;
    r  = (mMode == M_FLT) ? 4'b0000 : 4'((1 << mN) - 1);
    st = ((mMode == M_UP) || (mMode == M_DOWN)) && (mT >= 1);
    return {r, mMode == M_ON, mMode == M_FLT, mFR, st,
            (mMode == M_OFF) || (mMode == M_FLT)};
  endfunction

  task automatic modelReset();
    mMode  = M_OFF;
    mN     = 0;
    mT     = 0;
    mFR    = 2'd0;
    mPrevV = modelVec();
  endtask

  task automatic goFault(input int r);
    mMode = M_FLT;
    mFR   = 2'(r);
    mN    = 0;
  endtask

  // One clock edge of the reference model; step spacing is C+2 edges.
  task automatic modelStep(input logic en, input logic [3:0] pg);
    int         lb;
    logic [9:0] v;
    exp_t       e;
    case (mMode)
      M_OFF: if (en) begin mMode = M_UP; mN = 1; mT = 0; end
      M_UP: begin
        lb = lowestBad(pg, mN - 1);
        if (mT == 0) mT = 1;
        else if (lb >= 0) goFault(lb);
        else if (!en) begin mMode = M_DOWN; mN = mN - 1; mT = 0; end
        else if (mT == C + 1) begin
          if (!pg[mN-1]) goFault(mN - 1);
          else if (mN == RAILS) begin mMode = M_ON; mT = 0; end
          else begin mN = mN + 1; mT = 0; end
        end else mT = mT + 1;
      end
      M_ON: begin
        lb = lowestBad(pg, RAILS);
        if (lb >= 0) goFault(lb);
        else if (!en) begin mMode = M_DOWN; mN = RAILS - 1; mT = 0; end
      end
      M_DOWN: begin
        if (mT == C + 1) begin
          if (mN == 0) mMode = M_OFF;
          else begin mN = mN - 1; mT = 0; end
        end else mT = mT + 1;
      end
      M_FLT: if (!en) mMode = M_OFF;
      default: mMode = M_OFF;
    endcase
    v = modelVec();
    if (v !== mPrevV) begin
      e.cyc = edgeCnt;
      e.v   = v;
      expQ.push_back(e);
      mPrevV = v;
    end
  endtask

  task automatic cycle(input logic en, input logic [3:0] pg);
    bus.iEn      = en;
    bus.iPwrGood = pg;
    @(posedge iClk);
    #1;
    modelStep(en, pg);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_railEn"},    8'(bus.oRailEn),    8'h0);
    check({tag, "_ready"},     8'(bus.oReady),     8'h0);
    check({tag, "_fault"},     8'(bus.oFault),     8'h0);
    check({tag, "_faultRail"}, 8'(bus.oFaultRail), 8'h0);
    check({tag, "_dlyStart"},  8'(bus.oDlyStart),  8'h0);
    check({tag, "_dlyClr"},    8'(bus.oDlyClr),    8'h1);
  endtask

  // Monitor: every change of the DUT output vector must match the next
  // expected event, both in value and in the edge it appeared on.
  initial begin
    logic [9:0] cur;
    logic [9:0] lastV;
    exp_t       e;
    lastV = '0;
    forever begin
      @(negedge iClk);
      cur = {bus.oRailEn, bus.oReady, bus.oFault, bus.oFaultRail,
             bus.oDlyStart, bus.oDlyClr};
      if (iRst) lastV = cur;
      else if (cur !== lastV) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL output_event: got %b at edge %0d, expected no change", cur, edgeCnt);
        end else begin
          e = expQ.pop_front();
          if (cur !== e.v || edgeCnt != e.cyc) begin
            bad++;
            $display("FAIL output_event: got %b at edge %0d, expected %b at edge %0d",
                     cur, edgeCnt, e.v, e.cyc);
          end
        end
        lastV = cur;
      end
    end
  end

  initial begin
    logic       en;
    logic [3:0] pg;
    int         r;

    iRst         = 1'b1;
    bus.iEn      = 1'b0;
    bus.iPwrGood = 4'hF;
    @(posedge iClk);
    #1;
    checkResetOutputs("reset");
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    modelReset();

    // Full power-up, then power-down.
    for (int i = 0; i < 30; i++) cycle(1'b1, 4'hF);
    for (int i = 0; i < 25; i++) cycle(1'b0, 4'hF);

    // Rail 2 never good: fault at its done, held while iEn stays high.
    for (int i = 0; i < 20; i++) cycle(1'b1, 4'b1011);
    for (int i = 0; i < 5; i++)  cycle(1'b0, 4'hF);

    // In ON, rails 1 and 3 fail on the same cycle iEn drops.
    for (int i = 0; i < 30; i++) cycle(1'b1, 4'hF);
    cycle(1'b0, 4'b0101);
    for (int i = 0; i < 5; i++)  cycle(1'b0, 4'hF);

    // Request drops while waiting on rail 1.
    for (int i = 0; i < 7; i++)  cycle(1'b1, 4'hF);
    for (int i = 0; i < 20; i++) cycle(1'b0, 4'hF);

    // Asynchronous reset with rails 0 and 1 on; oFaultRail still holds 1.
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'hF);
    @(negedge iClk);
    #2;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL pending_before_reset: got %0d queued expected 0", expQ.size());
    end
    iRst = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    expQ.delete();
    bus.iEn = 1'b0;
    @(posedge iClk);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    modelReset();

    // Randomized request and power-good activity.
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      pg = 4'hF;
      r  = $urandom_range(0, 59);
      if (r == 0) pg[$urandom_range(0, 3)] = 1'b0;
      if (r == 1) begin
        pg[$urandom_range(0, 3)] = 1'b0;
        pg[$urandom_range(0, 3)] = 1'b0;
      end
      cycle(en, pg);
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, 4'hF);

    @(negedge iClk);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: got %0d queued expected 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

Rail power-up/power-down sequencer that sits directly upstream of the `delay` counter block. It drives that counter's start/clear inputs and consumes its done flag to space rail enables. It enables RAILS rails in ascending order and disables them in descending order. It checks each rail's power-good and latches a fault with the failing rail index.

## Interface
Parameters:
- RAILS, default 4: number of sequenced rails; legal range 2..8.
- IDX_W, default clog2(RAILS): width of the rail index; minimum 1. Computed with the same clog2 function as `delay`.

Ports:
- iClk  input  1  system clock; all logic on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iEn  input  1  level request: high = power up, low = power down.
- iPwrGood  input  RAILS  per-rail power-good, synchronous to iClk.
- iDlyDone  input  1  done flag from the downstream `delay` instance.
- oDlyStart  output  1  to `delay` iStart; high only while waiting.
- oDlyClr  output  1  to `delay` iClrCnt; high in IDLE and FAULT.
- oRailEn  output  RAILS  rail enables.
- oReady  output  1  all rails up and good.
- oFault  output  1  sticky fault flag.
- oFaultRail  output  IDX_W  index of the faulting rail.

## Operation
- Rail index k, IDX_W bits. Seven states: IDLE, UP_EN, UP_WAIT, ON, DN_DIS, DN_WAIT, FAULT.
- All outputs are registered and decoded from the next state.
- Reset values: state IDLE, k=0, oRailEn=0, oReady=0, oFault=0, oFaultRail=0, oDlyStart=0, oDlyClr=1.
- IDLE:
  - iEn=1 → UP_EN with k=0.
- UP_EN: set oRailEn[k]=1, oDlyStart=0, then → UP_WAIT.
- UP_WAIT: oDlyStart=1. Priority order:
  1. Any iPwrGood[j]=0 with j<k → FAULT, oFaultRail = lowest such j.
  2. iEn=0 → DN_DIS, keeping the current k.
  3. iDlyDone=1 and iPwrGood[k]=1 → k==RAILS-1 ? ON : (k+1, UP_EN).
  4. iDlyDone=1 and iPwrGood[k]=0 → FAULT, oFaultRail=k.
- ON: oReady=1, oDlyStart=0.
  - Any iPwrGood bit 0 → FAULT, oFaultRail = lowest failing index. Fault takes priority over iEn=0.
  - Otherwise iEn=0 → DN_DIS with k=RAILS-1.
- DN_DIS: clear oRailEn[k], oReady=0, oDlyStart=0, then → DN_WAIT.
- DN_WAIT: oDlyStart=1. On iDlyDone=1: k==0 → IDLE, else k-1 → DN_DIS.
  - Power-good is ignored during power-down.
  - iEn re-asserting during power-down is ignored until IDLE is reached.
- FAULT: oRailEn=0 (all rails dropped at once), oReady=0, oFault=1, oDlyClr=1, oDlyStart=0.
  - Exit to IDLE only when iEn=0; oFault clears on that exit.
  - oFaultRail holds its value until the next fault or reset.
- The one-cycle oDlyStart=0 in UP_EN/DN_DIS clears the `delay` counter, so a stale iDlyDone is never sampled in a wait state.
- No arithmetic wraps: k increments only while below RAILS-1 and decrements only while above 0.

## Timing
- With a `delay` instance of COUNT=C:
  - iEn sampled high at edge e0 → oRailEn[0]=1 after e0.
  - oDlyStart rises after e1.
  - iDlyDone rises after e1+C.
  - oRailEn[1]=1 after e1+C+1.
- Rail-to-rail spacing is C+2 cycles, in both the up and down directions.
- oReady rises on the same edge the sequence enters ON, i.e. C+2 cycles after oRailEn[RAILS-1] rises.
- Fault response: one edge after the sampled bad iPwrGood, oRailEn=0 and oFault=1.
- Asynchronous reset at any point forces all outputs to their reset values immediately (rails drop without sequencing).
- iEn is sampled directly; the caller guarantees it is synchronous.

## Test plan
- RAILS=4, C=3, iPwrGood all 1, iEn pulsed high → oRailEn steps 0001, 0011, 0111, 1111 at 5-cycle spacing; oReady high 5 cycles after 1111.
- From ON, drop iEn → oReady=0 the next edge; oRailEn steps 0111, 0011, 0001, 0000 at 5-cycle spacing; state returns to IDLE.
- During power-up, hold iPwrGood[2]=0 → when done arrives for rail 2, oRailEn=0000, oFault=1, oFaultRail=2. Holding iEn=1 keeps the fault; iEn=0 clears oFault.
- In ON, pulse iPwrGood[1]=0 and iPwrGood[3]=0 on the same cycle, with iEn dropping on that cycle → FAULT wins, oFaultRail=1.
- Drop iEn while in UP_WAIT for rail 1 → rails 1 then 0 disable at 5-cycle spacing, no fault.
- Assert iRst mid-sequence with oRailEn=0011 → oRailEn=0, oDlyClr=1, oFault=0 asynchronously, before the next clock edge.
